// File: rtl/vga_fb_scheduler.sv
// Single-port frame-buffer arbiter: 2x-upscaled VGA display reads vs. loader writes to the back page,
// with tear-free page flips at vblank. Optional VGA_FB_STARVE_CNT_EN adds the wr_wait_cnt output.
module vga_fb_scheduler #(
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned FB_W       = 320,
  parameter int unsigned PAGE_WORDS = 76800,
  parameter int unsigned AW         = 18,
  parameter int unsigned DW         = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [10:0]   pixel_x,
  input  logic [10:0]   pixel_y,
  input  logic          video_en,
  input  logic          wr_req,
  input  logic [16:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  output logic          wr_err,
  input  logic          flip_req,
  output logic          flip_pend,
  output logic          flip_done,
  output logic          front_page,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rgb_out,
  output logic          de_out
`ifdef VGA_FB_STARVE_CNT_EN
  ,
  output logic [15:0]   wr_wait_cnt
`endif
);

  // FB_W is split into two power-of-two terms so the row offset is a pair of shifts.
  localparam int unsigned     SH_HI     = $clog2(FB_W) - 1;
  localparam int unsigned     SH_LO     = $clog2(FB_W - (1 << SH_HI));
  localparam logic [10:0]     H_ACT_L   = 11'(H_ACT);
  localparam logic [10:0]     V_ACT_L   = 11'(V_ACT);
  localparam logic [16:0]     PAGE_L    = 17'(PAGE_WORDS);
  localparam logic [AW-1:0]   PAGE_BASE = AW'(PAGE_WORDS);

  typedef enum logic {SHOW, PEND} page_state_t;

  page_state_t   state, state_nxt;
  logic          front_nxt, flip_done_nxt;
  logic          disp_slot, boundary, grant, addr_err;
  logic [AW-1:0] y_off, rd_addr, wr_addr_full;
  logic [1:0]    de_pipe, rd_pipe;

  always_comb begin
    disp_slot    = video_en && !pixel_x[0] && (pixel_x < H_ACT_L) && (pixel_y < V_ACT_L);
    boundary     = (pixel_y == V_ACT_L) && (pixel_x == '0);
    grant        = !disp_slot && wr_req && !wr_gnt;
    addr_err     = (wr_addr >= PAGE_L);
    y_off        = (AW'(pixel_y[9:1]) << SH_HI) + (AW'(pixel_y[9:1]) << SH_LO);
    rd_addr      = (front_page ? PAGE_BASE : '0) + y_off + AW'(pixel_x[10:1]);
    wr_addr_full = (front_page ? '0 : PAGE_BASE) + AW'(wr_addr);
  end

  // Memory port, write handshake and display pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_gnt    <= 1'b0;
      wr_err    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      de_pipe   <= '0;
      rd_pipe   <= '0;
      de_out    <= 1'b0;
      rgb_out   <= '0;
    end else begin
      wr_gnt <= grant;
      wr_err <= grant && addr_err;
      mem_we <= grant && !addr_err;
      if (disp_slot) begin
        mem_addr <= rd_addr;
      end else if (grant && !addr_err) begin
        mem_addr  <= wr_addr_full;
        mem_wdata <= wr_data;
      end
      de_pipe <= {de_pipe[0], video_en};
      rd_pipe <= {rd_pipe[0], disp_slot};
      de_out  <= de_pipe[1];
      // rd_pipe[1] marks the cycle in which the RAM returns an even-pixel read; odd pixels hold it.
      if (!de_pipe[1]) begin
        rgb_out <= '0;
      end else if (rd_pipe[1]) begin
        rgb_out <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SHOW;
      front_page <= 1'b0;
      flip_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      front_page <= front_nxt;
      flip_done  <= flip_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    front_nxt     = front_page;
    flip_done_nxt = 1'b0;
    case (state)
      SHOW: if (flip_req) state_nxt = PEND;
      PEND: if (boundary) begin
        state_nxt     = SHOW;
        front_nxt     = ~front_page;
        flip_done_nxt = 1'b1;
      end
    endcase
  end

  assign flip_pend = (state == PEND);

`ifdef VGA_FB_STARVE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || boundary) begin
      wr_wait_cnt <= '0;
    end else if (wr_req && !grant && (wr_wait_cnt != '1)) begin
      wr_wait_cnt <= wr_wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Self-checking bench for vga_fb_scheduler: vector table, directed corner sequences and a
// randomized scan/write mix checked against a cycle-level behavioural model and a RAM image.
module tb_vga_fb_scheduler;
  localparam int PAGE = 76800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] pixel_x, pixel_y;
  logic        video_en, wr_req, flip_req;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_gnt, wr_err, flip_pend, flip_done, front_page, mem_we, de_out;
  logic [17:0] mem_addr;
  logic [11:0] mem_wdata, mem_rdata, rgb_out;
`ifdef VGA_FB_STARVE_CNT_EN
  logic [15:0] wr_wait_cnt;
  int          m_cnt;
`endif

  always #5 clk = ~clk;

  vga_fb_scheduler dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_en(video_en),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_err(wr_err),
    .flip_req(flip_req), .flip_pend(flip_pend), .flip_done(flip_done), .front_page(front_page),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rgb_out(rgb_out), .de_out(de_out)
`ifdef VGA_FB_STARVE_CNT_EN
    , .wr_wait_cnt(wr_wait_cnt)
`endif
  );

  // Synchronous-read RAM with both pages preloaded as word = address[11:0].
  logic [11:0] ram     [0:2*PAGE-1];
  logic [11:0] ref_mem [0:2*PAGE-1];
  initial begin
    for (int i = 0; i < 2*PAGE; i++) ram[i] = i[11:0];
    forever begin
      @(posedge clk);
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct { bit chk; bit de; int rgb; } hent_t;
  typedef struct { int x; int y; bit ven; bit req; int wa; int wd; bit g; bit e; bit w; int a; } vec_t;

  hent_t hist[$];
  int    wr_log[$];
  int    checks = 0, errors = 0;
  int    m_front, m_pend, m_addr, m_wdata, prev_x, prev_y;
  bit    m_gnt, m_err, m_we, m_done, prev_ven;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Advance one clock: predict from the current inputs, then compare after the edge.
  task automatic cyc();
    hent_t h;
    bit disp, bnd, grant, err;
    int px, py, wa, a;
    px = int'(pixel_x); py = int'(pixel_y); wa = int'(wr_addr); a = 0;
    if (!rst_n) begin
      m_front = 0; m_pend = 0; m_addr = 0; m_wdata = 0;
      m_gnt = 0; m_err = 0; m_we = 0; m_done = 0; prev_ven = 0;
      hist.delete();
`ifdef VGA_FB_STARVE_CNT_EN
      m_cnt = 0;
`endif
    end else begin
      disp  = video_en && (px % 2 == 0);
      bnd   = (py == 480) && (px == 0);
      grant = !disp && wr_req && !m_gnt;
      err   = wa >= PAGE;
      if (video_en) a = m_front*PAGE + (py/2)*320 + px/2;
      h.de  = video_en;
      h.chk = !video_en || (px % 2 == 0) || (prev_ven && prev_x + 1 == px && prev_y == py);
      h.rgb = video_en ? int'(ref_mem[a]) : 0;
      hist.push_back(h);
      prev_ven = video_en; prev_x = px; prev_y = py;
      m_gnt = grant; m_err = grant && err; m_we = grant && !err;
      if (disp) m_addr = a;
      else if (m_we) begin
        m_addr = (1 - m_front)*PAGE + wa;
        m_wdata = int'(wr_data);
        ref_mem[m_addr] = wr_data;
        wr_log.push_back(m_addr);
      end
`ifdef VGA_FB_STARVE_CNT_EN
      if (bnd) m_cnt = 0;
      else if (wr_req && !grant && m_cnt < 65535) m_cnt++;
`endif
      m_done = 0;
      if (m_pend == 1 && bnd) begin m_front = 1 - m_front; m_pend = 0; m_done = 1; end
      else if (m_pend == 0 && flip_req) m_pend = 1;
    end
    @(posedge clk); #1;
    chk("wr_gnt", wr_gnt, m_gnt);
    chk("wr_err", wr_err, m_err);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("front_page", front_page, m_front);
    chk("flip_pend", flip_pend, m_pend);
    chk("flip_done", flip_done, m_done);
`ifdef VGA_FB_STARVE_CNT_EN
    chk("wr_wait_cnt", wr_wait_cnt, m_cnt);
`endif
    if (hist.size() == 3) begin
      h = hist.pop_front();
      chk("de_out", de_out, h.de);
      if (h.chk) chk("rgb_out", rgb_out, h.rgb);
    end else begin
      chk("de_out_flushed", de_out, 0);
      chk("rgb_out_flushed", rgb_out, 0);
    end
  endtask

  task automatic drive(int x, int y);
    pixel_x  = 11'(x);
    pixel_y  = 11'(y);
    video_en = (x < 640) && (y < 480);
    cyc();
  endtask

  vec_t vt[9];
  int   n;
  bit   hold;

  initial begin
    for (int i = 0; i < 2*PAGE; i++) ref_mem[i] = i[11:0];
    rst_n = 0; pixel_x = '0; pixel_y = '0; video_en = 0;
    wr_req = 0; wr_addr = '0; wr_data = '0; flip_req = 0;
    cyc(); cyc();
    chk("rst_front", front_page, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rgb", rgb_out, 0);
    rst_n = 1;

    // x, y, ven, req, wr_addr, wr_data -> gnt, err, we, mem_addr
    vt[0] = '{0,   0,   1, 0, 0,     0,     0, 0, 0, 0};
    vt[1] = '{2,   0,   1, 0, 0,     0,     0, 0, 0, 1};
    vt[2] = '{0,   2,   1, 0, 0,     0,     0, 0, 0, 320};
    vt[3] = '{638, 479, 1, 0, 0,     0,     0, 0, 0, 76799};
    vt[4] = '{1,   0,   1, 1, 5,     'hABC, 1, 0, 1, 76805};
    vt[5] = '{0,   0,   1, 1, 5,     'hABC, 0, 0, 0, 0};
    vt[6] = '{700, 10,  0, 1, 76800, 'h321, 1, 1, 0, 0};
    vt[7] = '{700, 10,  0, 1, 76799, 'h123, 1, 0, 1, 153599};
    vt[8] = '{700, 10,  0, 1, 1000,  'hFFF, 1, 0, 1, 77800};
    for (int i = 0; i < 9; i++) begin
      pixel_x = 11'(vt[i].x); pixel_y = 11'(vt[i].y); video_en = vt[i].ven;
      wr_req = vt[i].req; wr_addr = 17'(vt[i].wa); wr_data = 12'(vt[i].wd);
      cyc();
      chk("vec_gnt", wr_gnt, vt[i].g);
      chk("vec_err", wr_err, vt[i].e);
      chk("vec_we", mem_we, vt[i].w);
      chk("vec_addr", mem_addr, vt[i].a);
      wr_req = 0;
      drive(700, 10);
    end

    // Display scan corners: first pixels, row 2, last active pixel pair.
    for (int x = 0; x < 10; x++) drive(x, 0);
    for (int x = 0; x < 6; x++) drive(x, 2);
    for (int x = 630; x < 640; x++) drive(x, 479);
    for (int k = 0; k < 4; k++) drive(700, 479);

    // Write held through active video: granted only on odd x, never displacing a read.
    wr_req = 1; wr_addr = 17'd5; wr_data = 12'hABC; n = 0;
    for (int x = 0; x < 20; x++) begin
      drive(x, 4);
      if (wr_gnt) begin
        n++;
        chk("gnt_odd_x", x % 2, 1);
        chk("act_wr_addr", mem_addr, 76805);
      end
    end
    chk("act_gnt_count", n, 10);
    wr_req = 0;

    // Back-to-back writes during blanking: one grant every second clock.
    wr_req = 1; wr_addr = 17'd100; wr_data = 12'h001; n = 0;
    for (int k = 0; k < 20; k++) begin
      drive(k, 500);
      if (wr_gnt) n++;
      if (m_gnt) begin wr_addr = wr_addr + 17'd1; wr_data = wr_data + 12'd1; end
    end
    chk("b2b_gnt_count", n, 10);
    wr_req = 0;

    // Two flip requests mid-frame give one flip at (0,480); a write on that edge hits the old back page.
    n = 0;
    for (int x = 0; x < 8; x++) begin
      flip_req = (x == 2) || (x == 6);
      drive(x, 100);
      if (flip_done) n++;
    end
    flip_req = 0;
    chk("pend_mid_frame", flip_pend, 1);
    for (int x = 630; x < 640; x++) begin drive(x, 479); if (flip_done) n++; end
    drive(700, 479); if (flip_done) n++;
    wr_req = 1; wr_addr = 17'd7; wr_data = 12'h5A5;
    drive(0, 480); if (flip_done) n++;
    chk("bnd_front", front_page, 1);
    chk("bnd_wr_addr", mem_addr, 76807);
    chk("bnd_we", mem_we, 1);
    wr_req = 0;
    drive(1, 480); if (flip_done) n++;
    drive(0, 0); if (flip_done) n++;
    drive(1, 0); if (flip_done) n++;
    drive(2, 0); if (flip_done) n++;
    chk("page1_word0", rgb_out, 12'hC00);
    drive(3, 0); if (flip_done) n++;
    chk("page1_word0_hold", rgb_out, 12'hC00);
    drive(4, 0); drive(5, 0); drive(700, 0); drive(700, 0); drive(700, 0);
    chk("flip_done_count", n, 1);

    // Reset for one edge right after a grant and while a flip is pending.
    flip_req = 1; drive(700, 300); flip_req = 0;
    wr_req = 1; wr_addr = 17'd9; wr_data = 12'h111;
    drive(700, 300);
    rst_n = 0; drive(700, 300); rst_n = 1;
    chk("rst_gnt", wr_gnt, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_pend", flip_pend, 0);
    chk("rst_front_mid", front_page, 0);
    chk("rst_de", de_out, 0);
`ifdef VGA_FB_STARVE_CNT_EN
    chk("rst_wait_cnt", wr_wait_cnt, 0);
`endif
    wr_req = 0;
    drive(0, 480);
    chk("no_flip_after_rst", front_page, 0);
    chk("no_done_after_rst", flip_done, 0);

    // Randomized scan segments with a random requester and occasional flip requests.
    hold = 0;
    for (int s = 0; s < 220; s++) begin
      int y, x0, len;
      y = int'($urandom_range(524, 0));
      x0 = 2 * int'($urandom_range(400, 0));
      len = int'($urandom_range(24, 2));
      if ($urandom % 10 == 0) begin y = 480; x0 = 0; end
      for (int i = 0; i < len; i++) begin
        if (!hold && ($urandom % 3 == 0)) begin
          hold = 1; wr_req = 1;
          wr_addr = ($urandom % 8 == 0) ? 17'(PAGE + int'($urandom % 50000)) : 17'($urandom % PAGE);
          wr_data = 12'($urandom);
        end
        flip_req = ($urandom % 150 == 0);
        drive(x0 + i, y);
        if (m_gnt) begin hold = 0; wr_req = 0; end
      end
    end
    wr_req = 0; flip_req = 0;
    for (int k = 0; k < 4; k++) drive(700, 500);

    foreach (wr_log[i]) chk("ram_word", ram[wr_log[i]], ref_mem[wr_log[i]]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_fb_scheduler.md
Name: vga_fb_scheduler

Overview:
- Schedules the single-port frame-buffer memory between the VGA display fetch path and an image-loader write requester.
- Sits between the 640x480 VGA timing generator (pixel_x, pixel_y, video_en) and the frame-buffer RAM.
- Stores 320x240 pages, upscaled 2x on readout.
- Double-buffers two pages; page flips happen only at the start of vertical blanking, so the comic page swaps without tearing.

Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- FB_W, 320, stored page width in words
- PAGE_WORDS, 76800, words per page (FB_W*240)
- AW, 18, memory address width
- DW, 12, pixel width (RGB444)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- pixel_x  in  11  current x from timing generator
- pixel_y  in  11  current y from timing generator
- video_en  in  1  active-video flag from timing generator
- wr_req  in  1  loader write request
- wr_addr  in  17  word offset within the back page
- wr_data  in  DW  loader write data
- wr_gnt  out  1  one-cycle write-accepted pulse
- wr_err  out  1  one-cycle pulse: wr_addr out of range
- flip_req  in  1  request a front/back page swap
- flip_pend  out  1  swap requested, not yet done
- flip_done  out  1  one-cycle pulse when swap takes effect
- front_page  out  1  page currently displayed
- mem_addr  out  AW  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DW  RAM write data (registered)
- mem_rdata  in  DW  RAM read data, 1-cycle synchronous read
- rgb_out  out  DW  display pixel
- de_out  out  1  video_en delayed to align with rgb_out

Behaviour:
- Reset, sampled on clk edge with rst_n=0:
  - All outputs 0.
  - front_page=0, page FSM=SHOW.
  - Display pipeline flushed.
  - Takes effect mid-frame or mid-write; a pending flip or write is discarded.
- Slot rule, evaluated per cycle:
  - DISP slot when video_en=1 and pixel_x[0]=0.
  - Every other cycle is a FREE slot.
  - Display always wins its slot; no back-pressure exists on the display path.
- Display read:
  - Registered mem_addr = front_page*PAGE_WORDS + pixel_y[9:1]*FB_W + pixel_x[10:1].
  - Multiply done as (y<<8)+(y<<6).
  - mem_we=0 on a display read.
- Display latency:
  - mem_rdata is captured into rgb_out 3 clocks after the coordinates were presented.
  - rgb_out holds for 2 clocks, covering the even pixel and the following odd pixel.
  - de_out is video_en delayed by 3 clocks.
  - rgb_out=0 whenever de_out=0.
- Write grant:
  - Granted on a FREE-slot edge when wr_req=1 and wr_gnt is currently 0.
  - On that edge, register mem_we=1, mem_addr=(~front_page)*PAGE_WORDS+wr_addr, mem_wdata=wr_data, wr_gnt=1.
  - The requester holds wr_req/wr_addr/wr_data stable until it sees wr_gnt.
  - No grant in the cycle while wr_gnt=1, so the maximum write rate is 1 per 2 clocks.
  - Writes always target the back page; the front page is never written.
- Range check:
  - wr_addr >= PAGE_WORDS: wr_gnt=1 and wr_err=1 for the same cycle, mem_we=0, no write.
- Idle cycle (FREE slot, no grant): mem_we=0, mem_addr holds its last value.
- Page FSM:
  - SHOW, flip_req=1 -> PEND; flip_pend=1.
  - PEND, pixel_y==V_ACT and pixel_x==0 -> front_page toggles, flip_done pulses 1 cycle, flip_pend=0, -> SHOW.
  - flip_req while in PEND is ignored; exactly one flip results.
  - flip_req in SHOW on the boundary cycle itself -> PEND; the flip occurs at the next frame's boundary.
  - A write granted on the boundary cycle goes to the back page as it was before the toggle.
- No other wrap-around: all address sums fit in AW bits; pixel_x/pixel_y beyond the active area never generate reads.

Optional Feature:
- Macro: VGA_FB_STARVE_CNT_EN.
- Defined:
  - Adds output wr_wait_cnt [15:0].
  - Counts cycles with wr_req=1 and no grant.
  - Saturates at 16'hFFFF.
  - Clears to 0 at each flip-boundary cycle (pixel_y==V_ACT, pixel_x==0) and on reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then free-run a 640x480 frame with RAM preloaded as word value = address[11:0]:
  - coords (0,0) -> rgb_out=0x000 at clk+3, held 2 clocks.
  - (2,0) -> 0x001.
  - (0,2) -> 0x140.
  - (639,479) -> word 76799.
- wr_req held with wr_addr=5, wr_data=0xABC during active video:
  - grant only on an odd-x cycle.
  - mem_addr=76805 (back page 1), mem_we=1.
  - display reads never displaced.
- Back-to-back requests during blanking: gnt pulses every 2nd clock; 10 writes complete in 20 clocks.
- wr_addr=76800 -> wr_gnt=1, wr_err=1, mem_we=0.
- flip_req pulsed twice mid-frame:
  - flip_pend=1 until (0,480).
  - front_page 0->1 exactly at that edge, a single flip_done pulse.
  - next frame reads base 76800.
- rst_n=0 for one edge mid-write and mid-PEND:
  - all outputs 0, front_page=0, no flip.
  - with VGA_FB_STARVE_CNT_EN, wr_wait_cnt=0.
